// File: rtl/instr_stream_encoder_pkg.sv
// Shared definitions for the instruction stream encoder.
// Contents:
//   OP_DP/OP_MEM/OP_BR  - op field encodings
//   BR_FUNCT_HI         - required funct[5:4] value for a legal branch tuple
//   enc_state_t         - load-session FSM states
//   instr_fields_t      - decoded field tuple presented at the encoder input
package instr_stream_encoder_pkg;

  localparam logic [1:0] OP_DP       = 2'b00;
  localparam logic [1:0] OP_MEM      = 2'b01;
  localparam logic [1:0] OP_BR       = 2'b10;
  localparam logic [1:0] BR_FUNCT_HI = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    FULL = 2'd3
  } enc_state_t;

  typedef struct packed {
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [11:0] src2;
    logic [23:0] imm24;
  } instr_fields_t;

endpackage

// File: rtl/instr_stream_encoder_packer.sv
// instr_field_packer: combinational fields -> 32-bit ARM word.
// Ports:
//   i_fields  - decoded field tuple
//   o_word    - encoded instruction word
//   o_illegal - tuple is not a legal encoding (op 11, or branch with funct[5:4] != 10)
module instr_field_packer
  import instr_stream_encoder_pkg::*;
(
  input  instr_fields_t i_fields,
  output logic [31:0]   o_word,
  output logic          o_illegal
);

  // Branches carry a 24-bit offset in place of rn/rd/src2; all other ops use the flat layout.
  always_comb begin
    o_word = 32'h0000_0000;
    if (i_fields.op == OP_BR) begin
      o_word = {i_fields.cond, i_fields.op, i_fields.funct[5:4], i_fields.imm24};
    end else begin
      o_word = {i_fields.cond, i_fields.op, i_fields.funct,
                i_fields.rn, i_fields.rd, i_fields.src2};
    end
  end

  // Illegal-tuple classification; only consumed when checking is built in.
  always_comb begin
    o_illegal = 1'b0;
    if (i_fields.op == 2'b11) begin
      o_illegal = 1'b1;
    end else if ((i_fields.op == OP_BR) && (i_fields.funct[5:4] != BR_FUNCT_HI)) begin
      o_illegal = 1'b1;
    end else begin
      o_illegal = 1'b0;
    end
  end

endmodule

// File: rtl/instr_stream_encoder.sv
// instr_stream_encoder: packs field tuples into ARM words and streams them into
// instruction memory at incrementing byte addresses, one word per accepted tuple.
// Optional feature macro: ENCODER_CHECK_EN (illegal tuples are accepted but not
// written, and raise the sticky err flag).
// Ports:
//   clk, reset             - clock, asynchronous active-high reset
//   start                  - pulse: open a new load session
//   in_valid/in_ready      - field tuple handshake; in_last marks the final word
//   cond/op/funct/rn/rd/src2/imm24 - decoded fields
//   mem_we/mem_addr/mem_wd - registered instruction-memory write port
//   busy                   - session in progress (LOAD)
//   done                   - last word written, held until start/reset
//   count                  - words written this session
//   overflow               - sticky: DEPTH reached without in_last
//   err                    - sticky illegal-tuple flag (0 when checking is not built)
module instr_stream_encoder
  import instr_stream_encoder_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                DEPTH     = 64,
  localparam int               CW        = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [3:0]        cond,
  input  logic [1:0]        op,
  input  logic [5:0]        funct,
  input  logic [3:0]        rn,
  input  logic [3:0]        rd,
  input  logic [11:0]       src2,
  input  logic [23:0]       imm24,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wd,
  output logic              busy,
  output logic              done,
  output logic [CW-1:0]     count,
  output logic              overflow,
  output logic              err
);

  enc_state_t        r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [CW-1:0]     r_count;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wd;
  logic              r_done;
  logic              r_overflow;
  logic              r_err;

  instr_fields_t w_fields;
  logic [31:0]   w_word;
  logic          w_illegal;
  logic          w_drop;
  logic          w_accept;

  assign w_fields = '{cond: cond, op: op, funct: funct, rn: rn, rd: rd,
                      src2: src2, imm24: imm24};

  instr_field_packer u_packer (
    .i_fields  (w_fields),
    .o_word    (w_word),
    .o_illegal (w_illegal)
  );

`ifdef ENCODER_CHECK_EN
  assign w_drop = w_illegal;
`else
  logic w_unused_illegal;
  assign w_unused_illegal = w_illegal;
  assign w_drop           = 1'b0;
`endif

  // The count bound alone stops acceptance once the session is full.
  assign in_ready = (r_state == LOAD) & ~start & (r_count < CW'(DEPTH));
  assign w_accept = in_valid & in_ready;

  assign mem_we   = r_mem_we;
  assign mem_addr = r_mem_addr;
  assign mem_wd   = r_mem_wd;
  assign busy     = (r_state == LOAD);
  assign done     = r_done;
  assign count    = r_count;
  assign overflow = r_overflow;
  assign err      = r_err;

  // Load-session FSM, write pointer/counter and registered memory write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_ptr      <= BASE_ADDR;
      r_count    <= '0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_wd   <= 32'h0000_0000;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      // A write registered on the previous edge is already on the port, so a
      // start here never disturbs it; in_ready is low while start is high.
      if (start) begin
        r_state    <= LOAD;
        r_ptr      <= BASE_ADDR;
        r_count    <= '0;
        r_done     <= 1'b0;
        r_overflow <= 1'b0;
        r_err      <= 1'b0;
      end else if (w_accept) begin
        if (w_drop) begin
          r_err <= 1'b1;
        end else begin
          r_mem_we   <= 1'b1;
          r_mem_addr <= r_ptr;
          r_mem_wd   <= w_word;
          r_ptr      <= r_ptr + ADDR_W'(4);
          r_count    <= r_count + CW'(1);
        end
        // in_last wins over the full condition on the final slot.
        if (in_last) begin
          r_state <= DONE;
          r_done  <= 1'b1;
        end else if (!w_drop && (r_count == CW'(DEPTH - 1))) begin
          r_state    <= FULL;
          r_overflow <= 1'b1;
        end else begin
          r_state <= r_state;
        end
      end else begin
        r_state <= r_state;
      end
    end
  end

endmodule

// File: tb/tb_instr_stream_encoder.sv
module tb_instr_stream_encoder;
  localparam int DEPTH_T = 4;
  localparam int CW_T    = $clog2(DEPTH_T) + 1;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_last;
  logic [3:0]  cond, rn, rd;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [11:0] src2;
  logic [23:0] imm24;
  logic        in_ready, mem_we, busy, done, overflow, err;
  logic [31:0] mem_addr, mem_wd;
  logic [CW_T-1:0] count;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instr_stream_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0), .DEPTH(DEPTH_T)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .cond(cond), .op(op), .funct(funct), .rn(rn), .rd(rd),
    .src2(src2), .imm24(imm24), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .busy(busy), .done(done), .count(count), .overflow(overflow), .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
  endtask

  task automatic set_tuple(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                           input logic [3:0] n, input logic [3:0] d, input logic [11:0] s,
                           input logic [23:0] imm, input logic last);
    cond = c; op = o; funct = f; rn = n; rd = d; src2 = s; imm24 = imm;
    in_last = last; in_valid = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    cond = 4'h0; op = 2'b00; funct = 6'h00; rn = 4'h0; rd = 4'h0; src2 = 12'h000; imm24 = 24'h0;
    tick(); tick();
    n_vec++; if ({mem_we, busy, done, overflow, err, in_ready} !== 6'b000000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000000", {mem_we, busy, done, overflow, err, in_ready}); end
    n_vec++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_vec++; if (mem_addr !== 32'h0 || mem_wd !== 32'h0) begin
      n_fail++; $display("FAIL reset_port: got %h/%h want 0/0", mem_addr, mem_wd); end
    reset = 1'b0;
    tick();
    do_start();
    n_vec++; if (busy !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL start_load: busy %b in_ready %b want 1 1", busy, in_ready); end
  endtask

  task automatic test_dp_encode();
    set_tuple(4'hE, 2'b00, 6'b101000, 4'h1, 4'h2, 12'h003, 24'h0, 1'b0);
    tick();
    in_valid = 1'b0;
    n_vec++; if (mem_we !== 1'b1 || mem_addr !== 32'h0) begin
      n_fail++; $display("FAIL dp_write: we %b addr %h want 1 0", mem_we, mem_addr); end
    n_vec++; if (mem_wd !== 32'hE281_2003) begin n_fail++; $display("FAIL dp_word: got %h want e2812003", mem_wd); end
    n_vec++; if (count !== 3'd1) begin n_fail++; $display("FAIL dp_count: got %0d want 1", count); end
    tick();
    n_vec++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL dp_we_drop: got %b want 0", mem_we); end
  endtask

  task automatic test_branch_encode();
    do_start();
    set_tuple(4'hE, 2'b10, 6'b100000, 4'h0, 4'h0, 12'h000, 24'hFFFFFE, 1'b0);
    tick();
    in_valid = 1'b0;
    n_vec++; if (mem_we !== 1'b1 || mem_addr !== 32'h0 || mem_wd !== 32'hEAFF_FFFE) begin
      n_fail++; $display("FAIL br_word: we %b addr %h wd %h want 1 0 eafffffe", mem_we, mem_addr, mem_wd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_wd [3];
    exp_wd[0] = 32'h0593_4010; exp_wd[1] = 32'hE002_0391; exp_wd[2] = 32'h0A00_0010;
    do_start();
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: set_tuple(4'h0, 2'b01, 6'b011001, 4'h3, 4'h4, 12'h010, 24'h0, 1'b0);
        1: set_tuple(4'hE, 2'b00, 6'b000000, 4'h2, 4'h0, 12'h391, 24'h0, 1'b0);
        default: set_tuple(4'h0, 2'b10, 6'b100000, 4'h0, 4'h0, 12'h000, 24'h000010, 1'b1);
      endcase
      tick();
      n_vec++; if (mem_we !== 1'b1 || mem_addr !== 32'(4 * i) || mem_wd !== exp_wd[i]) begin
        n_fail++; $display("FAIL b2b_write%0d: we %b addr %h wd %h want 1 %h %h",
                           i, mem_we, mem_addr, mem_wd, 32'(4 * i), exp_wd[i]); end
    end
    n_vec++; if (done !== 1'b1 || count !== 3'd3 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_done: done %b count %0d in_ready %b want 1 3 0", done, count, in_ready); end
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    n_vec++; if (mem_we !== 1'b0 || done !== 1'b1) begin
      n_fail++; $display("FAIL b2b_idle: we %b done %b want 0 1", mem_we, done); end
  endtask

  task automatic test_overflow();
    int writes = 0;
    do_start();
    set_tuple(4'hE, 2'b00, 6'b000100, 4'h5, 4'h6, 12'h0AB, 24'h0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (mem_we === 1'b1) begin
        n_vec++; if (mem_addr !== 32'(4 * writes)) begin
          n_fail++; $display("FAIL ovf_addr%0d: got %h want %h", writes, mem_addr, 32'(4 * writes)); end
        writes++;
      end
    end
    n_vec++; if (writes != DEPTH_T) begin n_fail++; $display("FAIL ovf_writes: got %0d want 4", writes); end
    n_vec++; if (overflow !== 1'b1 || count !== 3'd4 || in_ready !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL ovf_state: ovf %b count %0d rdy %b done %b busy %b want 1 4 0 0 0",
                         overflow, count, in_ready, done, busy); end
    in_valid = 1'b0;
  endtask

  task automatic test_last_at_depth();
    do_start();
    set_tuple(4'h1, 2'b01, 6'b000001, 4'h7, 4'h8, 12'h004, 24'h0, 1'b0);
    tick(); tick(); tick();
    in_last = 1'b1;
    tick();
    n_vec++; if (mem_we !== 1'b1 || mem_addr !== 32'hC || done !== 1'b1 || overflow !== 1'b0 || count !== 3'd4) begin
      n_fail++; $display("FAIL last_depth: we %b addr %h done %b ovf %b count %0d want 1 c 1 0 4",
                         mem_we, mem_addr, done, overflow, count); end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic test_reset_mid_stream();
    do_start();
    set_tuple(4'hE, 2'b00, 6'b101000, 4'h1, 4'h2, 12'h003, 24'h0, 1'b0);
    tick(); tick();
    reset = 1'b1;
    #1;
    n_vec++; if (mem_we !== 1'b0 || count !== 3'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid: we %b count %0d busy %b want 0 0 0", mem_we, count, busy); end
    in_valid = 1'b0;
    #1 reset = 1'b0;
    tick();
    do_start();
    set_tuple(4'hE, 2'b00, 6'b101000, 4'h1, 4'h2, 12'h003, 24'h0, 1'b0);
    tick();
    in_valid = 1'b0;
    n_vec++; if (mem_we !== 1'b1 || mem_addr !== 32'h0 || count !== 3'd1) begin
      n_fail++; $display("FAIL rst_restart: we %b addr %h count %0d want 1 0 1", mem_we, mem_addr, count); end
  endtask

  task automatic test_start_in_flight();
    do_start();
    set_tuple(4'h2, 2'b00, 6'b001100, 4'h3, 4'h3, 12'h0FF, 24'h0, 1'b0);
    tick(); tick();
    start = 1'b1;
    #1;
    n_vec++; if (in_ready !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 32'h4) begin
      n_fail++; $display("FAIL start_flight: rdy %b we %b addr %h want 0 1 4", in_ready, mem_we, mem_addr); end
    tick();
    start = 1'b0; in_valid = 1'b0;
    n_vec++; if (mem_we !== 1'b0 || count !== 3'd0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL start_clear: we %b count %0d busy %b want 0 0 1", mem_we, count, busy); end
  endtask

  task automatic test_check();
    do_start();
    set_tuple(4'hE, 2'b00, 6'b101000, 4'h1, 4'h2, 12'h003, 24'h0, 1'b0);
    tick();
    set_tuple(4'hE, 2'b11, 6'b000001, 4'h1, 4'h2, 12'h345, 24'h0, 1'b0);
    tick();
    in_valid = 1'b0;
`ifdef ENCODER_CHECK_EN
    n_vec++; if (mem_we !== 1'b0 || count !== 3'd1 || err !== 1'b1) begin
      n_fail++; $display("FAIL chk_op11: we %b count %0d err %b want 0 1 1", mem_we, count, err); end
    set_tuple(4'hE, 2'b10, 6'b000000, 4'h0, 4'h0, 12'h000, 24'h000100, 1'b1);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    n_vec++; if (mem_we !== 1'b0 || count !== 3'd1 || done !== 1'b1 || err !== 1'b1) begin
      n_fail++; $display("FAIL chk_br_last: we %b count %0d done %b err %b want 0 1 1 1", mem_we, count, done, err); end
    do_start();
    n_vec++; if (err !== 1'b0) begin n_fail++; $display("FAIL chk_clear: err %b want 0", err); end
`else
    n_vec++; if (mem_we !== 1'b1 || mem_wd !== 32'hEC11_2345 || count !== 3'd2 || err !== 1'b0) begin
      n_fail++; $display("FAIL raw_op11: we %b wd %h count %0d err %b want 1 ec112345 2 0",
                         mem_we, mem_wd, count, err); end
`endif
  endtask

  initial begin
    test_reset();
    test_dp_encode();
    test_branch_encode();
    test_back_to_back();
    test_overflow();
    test_last_at_depth();
    test_reset_mid_stream();
    test_start_in_flight();
    test_check();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
